// File: rtl/mem_access_ctrl.sv
// Memory-stage data-access controller: issues one cache request per EX/MEM
// instruction, stalls until dhit, and tracks halt/misalign/timeout status.
module mem_access_ctrl #(
    parameter int          WAIT_MAX = 64,
    parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       ihit,
    input  logic                       dREN_in,
    input  logic                       dWEN_in,
    input  logic                       halt_in,
    input  logic [31:0]                aluresult_in,
    input  logic [31:0]                rdat2_in,
    input  logic                       dhit,
    input  logic [31:0]                dmemload,
    output logic                       dmemREN,
    output logic                       dmemWEN,
    output logic [31:0]                dmemaddr,
    output logic [31:0]                dmemstore,
    output logic [31:0]                dload_out,
    output logic                       mem_stall,
    output logic                       halted,
    output logic                       misalign_err,
    output logic                       timeout_err,
    output logic [$clog2(WAIT_MAX):0]  wait_cnt
);

    // state | meaning
    // IDLE  | accept a new EX/MEM op, issue request in the same cycle
    // WAIT  | request outstanding, counting cycles until dhit or timeout
    // DONE  | op finished, pipeline frozen; requests masked until ihit
    // HALT  | processor halted; left only through reset
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    localparam int           CW      = $clog2(WAIT_MAX) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [1:0]    r_state;
    logic [31:0]   r_dload;
    logic [CW-1:0] r_wait_cnt;
    logic          r_misalign_err;
    logic          r_timeout_err;
    logic          r_op_load;
    logic          r_op_store;

    logic w_acc;
    logic w_aligned;
    logic w_halted;
    logic w_req;
    logic w_ld;
    logic w_st;
    logic w_misalign;
    logic w_cnt_max;
    logic w_ren;
    logic w_wen;
    logic w_stall;
    logic w_capture;

    assign w_acc      = dREN_in | dWEN_in;
    assign w_aligned  = (aluresult_in[1:0] == 2'b00);
    assign w_halted   = (r_state == S_HALT);
    assign w_req      = w_acc & ~w_halted & w_aligned;
    // A simultaneous load and store request is treated as a store only.
    assign w_ld       = w_req & dREN_in & ~dWEN_in;
    assign w_st       = w_req & dWEN_in;
    assign w_misalign = w_acc & ~w_aligned & ~w_halted;
    assign w_cnt_max  = (r_wait_cnt == CNT_MAX);

    always_comb begin
        w_ren     = 1'b0;
        w_wen     = 1'b0;
        w_stall   = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ren     = w_ld;
                w_wen     = w_st;
                w_stall   = w_req & ~dhit;
                w_capture = w_ld & dhit;
            end
            S_WAIT: begin
                // The request is withdrawn in the cycle the wait budget runs out.
                w_ren     = r_op_load & ~w_cnt_max;
                w_wen     = r_op_store & ~w_cnt_max;
                w_stall   = ~dhit;
                w_capture = r_op_load & dhit;
            end
            default: begin
                w_ren     = 1'b0;
                w_wen     = 1'b0;
                w_stall   = 1'b0;
                w_capture = 1'b0;
            end
        endcase
        if (RST) begin
            w_ren   = 1'b0;
            w_wen   = 1'b0;
            w_stall = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state        <= S_IDLE;
            r_dload        <= 32'd0;
            r_wait_cnt     <= '0;
            r_misalign_err <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_op_load      <= 1'b0;
            r_op_store     <= 1'b0;
        end else begin
            if (w_misalign) begin
                r_misalign_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_op_load  <= w_ld;
                        r_op_store <= w_st;
                        if (dhit) begin
                            if (w_ld) begin
                                r_dload <= dmemload;
                            end
                            if (!ihit) begin
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_state    <= S_WAIT;
                            r_wait_cnt <= CNT_ONE;
                        end
                    end else if (halt_in && ihit) begin
                        r_state <= S_HALT;
                    end
                end
                S_WAIT: begin
                    if (dhit) begin
                        if (r_op_load) begin
                            r_dload <= dmemload;
                        end
                        if (ihit) begin
                            r_state    <= S_IDLE;
                            r_wait_cnt <= '0;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else if (w_cnt_max) begin
                        if (r_op_load) begin
                            r_dload <= ERR_WORD;
                        end
                        r_timeout_err <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_ONE;
                    end
                end
                S_DONE: begin
                    if (ihit) begin
                        r_wait_cnt <= '0;
                        r_state    <= halt_in ? S_HALT : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    assign dmemREN      = w_ren;
    assign dmemWEN      = w_wen;
    assign dmemaddr     = aluresult_in;
    assign dmemstore    = rdat2_in;
    assign dload_out    = w_capture ? dmemload : r_dload;
    assign mem_stall    = w_stall;
    assign halted       = w_halted;
    assign misalign_err = r_misalign_err;
    assign timeout_err  = r_timeout_err;
    assign wait_cnt     = r_wait_cnt;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a short wait budget (WAIT_MAX=4);
// inputs change on the falling edge and outputs are checked 1 time unit later.
module tb_mem_access_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dREN_in, dWEN_in, halt_in, dhit;
    logic [31:0] aluresult_in, rdat2_in, dmemload;
    logic        dmemREN, dmemWEN, mem_stall, halted, misalign_err, timeout_err;
    logic [31:0] dmemaddr, dmemstore, dload_out;
    logic [2:0]  wait_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    mem_access_ctrl #(.WAIT_MAX(4), .ERR_WORD(32'hBAD1BAD1)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dREN_in(dREN_in), .dWEN_in(dWEN_in),
        .halt_in(halt_in), .aluresult_in(aluresult_in), .rdat2_in(rdat2_in),
        .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dload_out(dload_out),
        .mem_stall(mem_stall), .halted(halted), .misalign_err(misalign_err),
        .timeout_err(timeout_err), .wait_cnt(wait_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic set_idle();
        ihit = 1'b0; dREN_in = 1'b0; dWEN_in = 1'b0; halt_in = 1'b0; dhit = 1'b0;
        aluresult_in = 32'd0; rdat2_in = 32'd0; dmemload = 32'hFFFF_FFFF;
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        set_idle();
        repeat (2) step();
        #1;
        n_chk++; if (dmemREN !== 1'b0) $display("FAIL rst_ren got %b want 0", dmemREN); else n_pass++;
        n_chk++; if (dmemWEN !== 1'b0) $display("FAIL rst_wen got %b want 0", dmemWEN); else n_pass++;
        n_chk++; if (mem_stall !== 1'b0) $display("FAIL rst_stall got %b want 0", mem_stall); else n_pass++;
        n_chk++; if ({halted, misalign_err, timeout_err} !== 3'b000) $display("FAIL rst_flags got %b want 000", {halted, misalign_err, timeout_err}); else n_pass++;
        n_chk++; if (dload_out !== 32'd0) $display("FAIL rst_dload got %h want 00000000", dload_out); else n_pass++;
        n_chk++; if (wait_cnt !== 3'd0) $display("FAIL rst_cnt got %0d want 0", wait_cnt); else n_pass++;
        step();
        RST = 1'b0;
    endtask

    task automatic test_load_hit();
        step();
        dREN_in = 1'b1; aluresult_in = 32'h100; dmemload = 32'h1234_5678; dhit = 1'b1; ihit = 1'b1;
        #1;
        n_chk++; if (dmemREN !== 1'b1) $display("FAIL ldhit_ren got %b want 1", dmemREN); else n_pass++;
        n_chk++; if (mem_stall !== 1'b0) $display("FAIL ldhit_stall got %b want 0", mem_stall); else n_pass++;
        n_chk++; if (dload_out !== 32'h1234_5678) $display("FAIL ldhit_dload got %h want 12345678", dload_out); else n_pass++;
        n_chk++; if (dmemaddr !== 32'h100) $display("FAIL ldhit_addr got %h want 00000100", dmemaddr); else n_pass++;
        step();
        set_idle();
        #1;
        n_chk++; if (dmemREN !== 1'b0) $display("FAIL ldhit_ren_after got %b want 0", dmemREN); else n_pass++;
        n_chk++; if (dload_out !== 32'h1234_5678) $display("FAIL ldhit_hold got %h want 12345678", dload_out); else n_pass++;
    endtask

    task automatic test_store_latency();
        step();
        dWEN_in = 1'b1; aluresult_in = 32'h200; rdat2_in = 32'hCAFE_F00D;
        #1;
        n_chk++; if ({dmemWEN, dmemREN, mem_stall} !== 3'b101) $display("FAIL st_c1 wen_ren_stall got %b want 101", {dmemWEN, dmemREN, mem_stall}); else n_pass++;
        n_chk++; if (dmemstore !== 32'hCAFE_F00D) $display("FAIL st_data got %h want cafef00d", dmemstore); else n_pass++;
        step(); #1;
        n_chk++; if ({dmemWEN, mem_stall} !== 2'b11) $display("FAIL st_c2 wen_stall got %b want 11", {dmemWEN, mem_stall}); else n_pass++;
        n_chk++; if (wait_cnt !== 3'd1) $display("FAIL st_c2_cnt got %0d want 1", wait_cnt); else n_pass++;
        step();
        dhit = 1'b1;
        #1;
        n_chk++; if ({dmemWEN, mem_stall} !== 2'b10) $display("FAIL st_c3 wen_stall got %b want 10", {dmemWEN, mem_stall}); else n_pass++;
        n_chk++; if (wait_cnt !== 3'd2) $display("FAIL st_c3_cnt got %0d want 2", wait_cnt); else n_pass++;
        step();
        dhit = 1'b0;
        #1;
        n_chk++; if ({dmemWEN, mem_stall} !== 2'b00) $display("FAIL st_c4 wen_stall got %b want 00", {dmemWEN, mem_stall}); else n_pass++;
        step();
        ihit = 1'b1;
        #1;
        n_chk++; if (dmemWEN !== 1'b0) $display("FAIL st_c5_noreissue got %b want 0", dmemWEN); else n_pass++;
        step();
        set_idle();
        #1;
        n_chk++; if (wait_cnt !== 3'd0) $display("FAIL st_exit_cnt got %0d want 0", wait_cnt); else n_pass++;
        n_chk++; if (dload_out !== 32'h1234_5678) $display("FAIL st_dload_kept got %h want 12345678", dload_out); else n_pass++;
        dREN_in = 1'b1; aluresult_in = 32'h204; dhit = 1'b1; dmemload = 32'h0BAD_F00D;
        #1;
        n_chk++; if ({dmemREN, mem_stall} !== 2'b10) $display("FAIL st_back_idle ren_stall got %b want 10", {dmemREN, mem_stall}); else n_pass++;
        dREN_in = 1'b0; dhit = 1'b0;
    endtask

    task automatic test_timeout();
        step();
        set_idle();
        dREN_in = 1'b1; aluresult_in = 32'h300;
        for (int c = 1; c <= 4; c++) begin
            #1;
            n_chk++; if ({dmemREN, mem_stall} !== 2'b11) $display("FAIL to_c%0d ren_stall got %b want 11", c, {dmemREN, mem_stall}); else n_pass++;
            step();
        end
        #1;
        n_chk++; if ({dmemREN, mem_stall, timeout_err} !== 3'b010) $display("FAIL to_c5 ren_stall_err got %b want 010", {dmemREN, mem_stall, timeout_err}); else n_pass++;
        n_chk++; if (wait_cnt !== 3'd4) $display("FAIL to_c5_cnt got %0d want 4", wait_cnt); else n_pass++;
        step(); #1;
        n_chk++; if ({dmemREN, mem_stall, timeout_err} !== 3'b001) $display("FAIL to_done ren_stall_err got %b want 001", {dmemREN, mem_stall, timeout_err}); else n_pass++;
        n_chk++; if (dload_out !== 32'hBAD1_BAD1) $display("FAIL to_dload got %h want bad1bad1", dload_out); else n_pass++;
        ihit = 1'b1;
        step();
        set_idle();
        #1;
        n_chk++; if ({dmemREN, mem_stall, timeout_err} !== 3'b001) $display("FAIL to_exit ren_stall_err got %b want 001", {dmemREN, mem_stall, timeout_err}); else n_pass++;
    endtask

    task automatic test_misalign();
        step();
        dREN_in = 1'b1; aluresult_in = 32'h102; dhit = 1'b1; dmemload = 32'h0000_0055; ihit = 1'b1;
        #1;
        n_chk++; if ({dmemREN, mem_stall} !== 2'b00) $display("FAIL mis_ren_stall got %b want 00", {dmemREN, mem_stall}); else n_pass++;
        n_chk++; if (dload_out !== 32'hBAD1_BAD1) $display("FAIL mis_dload got %h want bad1bad1", dload_out); else n_pass++;
        n_chk++; if (misalign_err !== 1'b0) $display("FAIL mis_not_yet got %b want 0", misalign_err); else n_pass++;
        step();
        dREN_in = 1'b0; dWEN_in = 1'b1; aluresult_in = 32'h201;
        #1;
        n_chk++; if ({dmemWEN, mem_stall, misalign_err} !== 3'b001) $display("FAIL mis_st wen_stall_err got %b want 001", {dmemWEN, mem_stall, misalign_err}); else n_pass++;
        step();
        set_idle();
        step(); #1;
        n_chk++; if (misalign_err !== 1'b1) $display("FAIL mis_sticky got %b want 1", misalign_err); else n_pass++;
    endtask

    task automatic test_back_to_back();
        step();
        dREN_in = 1'b1; aluresult_in = 32'h10; dmemload = 32'h1111_1111; dhit = 1'b1; ihit = 1'b1;
        #1;
        n_chk++; if (dload_out !== 32'h1111_1111) $display("FAIL b2b_ld1 got %h want 11111111", dload_out); else n_pass++;
        step();
        aluresult_in = 32'h14; dmemload = 32'h2222_2222;
        #1;
        n_chk++; if ({dmemREN, mem_stall} !== 2'b10) $display("FAIL b2b_ld2 ren_stall got %b want 10", {dmemREN, mem_stall}); else n_pass++;
        n_chk++; if (dload_out !== 32'h2222_2222) $display("FAIL b2b_ld2 got %h want 22222222", dload_out); else n_pass++;
        step();
        dWEN_in = 1'b1; aluresult_in = 32'h18; dmemload = 32'h3333_3333; rdat2_in = 32'h4444_4444;
        #1;
        n_chk++; if ({dmemREN, dmemWEN} !== 2'b01) $display("FAIL b2b_both ren_wen got %b want 01", {dmemREN, dmemWEN}); else n_pass++;
        n_chk++; if (dload_out !== 32'h2222_2222) $display("FAIL b2b_both_dload got %h want 22222222", dload_out); else n_pass++;
        step();
        set_idle();
        #1;
        n_chk++; if (dload_out !== 32'h2222_2222) $display("FAIL b2b_hold got %h want 22222222", dload_out); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        step();
        dWEN_in = 1'b1; aluresult_in = 32'h400; rdat2_in = 32'h5555_AAAA;
        #1;
        n_chk++; if (dmemWEN !== 1'b1) $display("FAIL rmw_issue got %b want 1", dmemWEN); else n_pass++;
        step();
        RST = 1'b1;
        #1;
        n_chk++; if ({dmemWEN, mem_stall} !== 2'b00) $display("FAIL rmw_in_rst wen_stall got %b want 00", {dmemWEN, mem_stall}); else n_pass++;
        step();
        RST = 1'b0;
        set_idle();
        #1;
        n_chk++; if ({dmemWEN, mem_stall, wait_cnt} !== 5'b0) $display("FAIL rmw_idle wen_stall_cnt got %b want 00000", {dmemWEN, mem_stall, wait_cnt}); else n_pass++;
        n_chk++; if ({halted, misalign_err, timeout_err} !== 3'b000) $display("FAIL rmw_flags got %b want 000", {halted, misalign_err, timeout_err}); else n_pass++;
        n_chk++; if (dload_out !== 32'd0) $display("FAIL rmw_dload got %h want 00000000", dload_out); else n_pass++;
    endtask

    task automatic test_halt();
        step();
        dREN_in = 1'b1; halt_in = 1'b1; aluresult_in = 32'h500; dmemload = 32'hA5A5_0001;
        #1;
        n_chk++; if ({dmemREN, mem_stall} !== 2'b11) $display("FAIL hlt_c1 ren_stall got %b want 11", {dmemREN, mem_stall}); else n_pass++;
        step();
        dhit = 1'b1;
        #1;
        n_chk++; if ({dmemREN, mem_stall} !== 2'b10) $display("FAIL hlt_c2 ren_stall got %b want 10", {dmemREN, mem_stall}); else n_pass++;
        n_chk++; if (dload_out !== 32'hA5A5_0001) $display("FAIL hlt_c2_dload got %h want a5a50001", dload_out); else n_pass++;
        step();
        dhit = 1'b0; ihit = 1'b1;
        #1;
        n_chk++; if ({dmemREN, halted} !== 2'b00) $display("FAIL hlt_c3 ren_halted got %b want 00", {dmemREN, halted}); else n_pass++;
        n_chk++; if (dload_out !== 32'hA5A5_0001) $display("FAIL hlt_c3_dload got %h want a5a50001", dload_out); else n_pass++;
        step();
        set_idle();
        #1;
        n_chk++; if (halted !== 1'b1) $display("FAIL hlt_c4 got %b want 1", halted); else n_pass++;
        step();
        dREN_in = 1'b1; aluresult_in = 32'h600; ihit = 1'b1;
        #1;
        n_chk++; if ({dmemREN, mem_stall, halted} !== 3'b001) $display("FAIL hlt_ld ren_stall_halted got %b want 001", {dmemREN, mem_stall, halted}); else n_pass++;
        step();
        aluresult_in = 32'h603;
        step(); #1;
        n_chk++; if ({misalign_err, halted} !== 2'b01) $display("FAIL hlt_mis err_halted got %b want 01", {misalign_err, halted}); else n_pass++;
    endtask

    initial begin
        RST = 1'b1;
        set_idle();
        test_reset();
        test_load_hit();
        test_store_latency();
        test_timeout();
        test_misalign();
        test_back_to_back();
        test_reset_mid_wait();
        test_halt();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
